// File: rtl/line_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : line_pkg
//  Brief    : Shared types and defaults for the line command scheduler:
//             FSM state encoding, coordinate/error widths, screen size.
//  Revision : 1.0  initial release
// ============================================================================
package line_pkg;

  // Scheduler control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW_DEFAULT    = 10;
  localparam int H_RES_DEFAULT = 640;
  localparam int V_RES_DEFAULT = 480;

  // Error term needs a sign bit plus one bit of headroom for 2*err
  function automatic int err_width(input int cw);
    return cw + 2;
  endfunction

  localparam int ERR_W_DEFAULT = err_width(CW_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/line_cmd_scheduler_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : bresenham_stepper
//  Brief    : All-octant Bresenham walker. load captures the endpoints and
//             derives dx/dy/sx/sy/err; each advance moves one pixel along
//             the line. at_end flags that the current point is the endpoint.
//  Revision : 1.0  initial release
// ============================================================================
module bresenham_stepper
  import line_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  output logic [CW-1:0] cur_x,
  output logic [CW-1:0] cur_y,
  output logic          at_end
);

  localparam int EW = err_width(CW);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  logic signed [EW-1:0] r_dx;
  logic signed [EW-1:0] r_dy;
  logic signed [EW-1:0] r_err;
  logic                 r_sx_neg;
  logic                 r_sy_neg;
  logic [CW-1:0]        r_x1;
  logic [CW-1:0]        r_y1;
  logic [CW-1:0]        r_cur_x;
  logic [CW-1:0]        r_cur_y;

  logic signed [EW-1:0] w_ddx;
  logic signed [EW-1:0] w_ddy;
  logic signed [EW-1:0] w_abs_dx;
  logic signed [EW-1:0] w_neg_ady;
  logic signed [EW-1:0] w_e2;
  logic signed [EW-1:0] w_add_x;
  logic signed [EW-1:0] w_add_y;
  logic                 w_step_x;
  logic                 w_step_y;
  logic [CW-1:0]        w_next_x;
  logic [CW-1:0]        w_next_y;

  // Setup terms from the raw endpoints, and the per-pixel step decision
  always_comb begin
    w_ddx     = $signed({2'b00, x1}) - $signed({2'b00, x0});
    w_ddy     = $signed({2'b00, y1}) - $signed({2'b00, y0});
    w_abs_dx  = w_ddx[EW-1] ? -w_ddx : w_ddx;
    w_neg_ady = w_ddy[EW-1] ? w_ddy : -w_ddy;
    // Both axis decisions are taken from the same (old) error value
    w_e2      = r_err <<< 1;
    w_step_x  = (w_e2 >= r_dy);
    w_step_y  = (w_e2 <= r_dx);
    w_add_x   = w_step_x ? r_dy : E_ZERO;
    w_add_y   = w_step_y ? r_dx : E_ZERO;
    w_next_x  = r_sx_neg ? (r_cur_x - CW'(1)) : (r_cur_x + CW'(1));
    w_next_y  = r_sy_neg ? (r_cur_y - CW'(1)) : (r_cur_y + CW'(1));
  end

  // Line state: initialised on load, walked one pixel per advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_cur_x  <= '0;
      r_cur_y  <= '0;
    end else if (load) begin
      r_dx     <= w_abs_dx;
      r_dy     <= w_neg_ady;
      r_err    <= w_abs_dx + w_neg_ady;
      r_sx_neg <= (x1 < x0);
      r_sy_neg <= (y1 < y0);
      r_x1     <= x1;
      r_y1     <= y1;
      r_cur_x  <= x0;
      r_cur_y  <= y0;
    end else if (advance) begin
      r_err <= r_err + w_add_x + w_add_y;
      if (w_step_x) r_cur_x <= w_next_x;
      if (w_step_y) r_cur_y <= w_next_y;
    end
  end

  assign cur_x  = r_cur_x;
  assign cur_y  = r_cur_y;
  assign at_end = (r_cur_x == r_x1) && (r_cur_y == r_y1);

endmodule
`default_nettype wire

// File: rtl/line_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : line_cmd_scheduler
//  Brief    : Round-robin arbiter over N_REQ line-draw requesters; runs one
//             Bresenham line at a time and streams pixels over valid/ready.
//             Optional off-screen clipping enabled by LINE_SCHED_CLIP_EN.
//  Revision : 1.0  initial release
// ============================================================================
module line_cmd_scheduler
  import line_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CW    = CW_DEFAULT,
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] req_x0,
  input  logic [N_REQ*CW-1:0] req_y0,
  input  logic [N_REQ*CW-1:0] req_x1,
  input  logic [N_REQ*CW-1:0] req_y1,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [CW-1:0]      pix_x,
  output logic [CW-1:0]      pix_y,
  output logic               busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef LINE_SCHED_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  localparam logic [CW:0] H_LIM = (CW+1)'(H_RES);
  localparam logic [CW:0] V_LIM = (CW+1)'(V_RES);

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [CW-1:0]   r_x0;
  logic [CW-1:0]   r_y0;
  logic [CW-1:0]   r_x1;
  logic [CW-1:0]   r_y1;

  logic            w_any;
  logic            w_hit_hi;
  logic [PW-1:0]   w_pick_hi;
  logic [PW-1:0]   w_pick_lo;
  logic [PW-1:0]   w_pick;
  logic [CW-1:0]   w_sel_x0;
  logic [CW-1:0]   w_sel_y0;
  logic [CW-1:0]   w_sel_x1;
  logic [CW-1:0]   w_sel_y1;
  logic            w_gnt_en;
  logic            w_take;
  logic            w_load;
  logic            w_adv;
  logic            w_fire;
  logic            w_visible;
  logic [CW-1:0]   w_cur_x;
  logic [CW-1:0]   w_cur_y;
  logic            w_at_end;

  // Round-robin pick: lowest requester at/above the pointer, else lowest overall
  always_comb begin
    w_any     = |req;
    w_hit_hi  = 1'b0;
    w_pick_hi = '0;
    w_pick_lo = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_pick_lo = PW'(i);
        if (PW'(i) >= r_ptr) begin
          w_pick_hi = PW'(i);
          w_hit_hi  = 1'b1;
        end
      end
    end
    w_pick = w_hit_hi ? w_pick_hi : w_pick_lo;
  end

  // Coordinate mux for the winning requester
  always_comb begin
    w_sel_x0 = '0;
    w_sel_y0 = '0;
    w_sel_x1 = '0;
    w_sel_y1 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick == PW'(i)) begin
        w_sel_x0 = req_x0[i*CW +: CW];
        w_sel_y0 = req_y0[i*CW +: CW];
        w_sel_x1 = req_x1[i*CW +: CW];
        w_sel_y1 = req_y1[i*CW +: CW];
      end
    end
  end

  // Grant is presented during the accepting IDLE cycle; reset masks it
  assign w_gnt_en = (r_state == IDLE) && w_any && !rst;
  assign w_take   = (r_state == IDLE) && w_any;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req_pulse
      assign gnt[gi]  = w_gnt_en && (w_pick == PW'(gi));
      assign done[gi] = (r_state == DONE) && (r_owner == PW'(gi));
    end
  endgenerate

  // Clipping hides off-screen pixels; without it every pixel is shown
  assign w_visible = !CLIP_EN ||
                     (({1'b0, w_cur_x} < H_LIM) && ({1'b0, w_cur_y} < V_LIM));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state, pixel handshake and stepper control
  always_comb begin
    w_state_next = r_state;
    w_adv        = 1'b0;
    w_fire       = 1'b0;
    pix_valid    = 1'b0;
    case (r_state)
      IDLE:  if (w_any) w_state_next = SETUP;
      SETUP: w_state_next = DRAW;
      DRAW: begin
        pix_valid = w_visible;
        // Hidden pixels retire on their own at one per cycle
        w_fire    = w_visible ? pix_ready : 1'b1;
        if (w_fire) begin
          if (w_at_end) w_state_next = DONE;
          else          w_adv        = 1'b1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_load = (r_state == SETUP);

  // Command capture on grant; pointer moves past the owner when its line ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
    end else if (w_take) begin
      r_owner <= w_pick;
      r_x0    <= w_sel_x0;
      r_y0    <= w_sel_y0;
      r_x1    <= w_sel_x1;
      r_y1    <= w_sel_y1;
    end else if (r_state == DONE) begin
      r_ptr <= (r_owner == PW'(N_REQ - 1)) ? '0 : (r_owner + PW'(1));
    end
  end

  bresenham_stepper #(
    .CW (CW)
  ) u_stepper (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .advance (w_adv),
    .x0      (r_x0),
    .y0      (r_y0),
    .x1      (r_x1),
    .y1      (r_y1),
    .cur_x   (w_cur_x),
    .cur_y   (w_cur_y),
    .at_end  (w_at_end)
  );

  assign pix_x = w_cur_x;
  assign pix_y = w_cur_y;
  assign busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_line_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_cmd_scheduler
//  Brief    : Scoreboard bench for line_cmd_scheduler. Stimulus pushes the
//             expected pixels and line completions; a monitor pops them as
//             the DUT hands pixels over and pulses done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_line_cmd_scheduler;

  localparam int N_REQ = 2;
  localparam int CW    = 10;

  typedef struct { int x; int y; } pix_t;
  typedef struct { int owner; int cnt; } line_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req = '0;
  logic [N_REQ*CW-1:0] req_x0 = '0;
  logic [N_REQ*CW-1:0] req_y0 = '0;
  logic [N_REQ*CW-1:0] req_x1 = '0;
  logic [N_REQ*CW-1:0] req_y1 = '0;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic                pix_valid;
  logic                pix_ready = 1'b1;
  logic [CW-1:0]       pix_x;
  logic [CW-1:0]       pix_y;
  logic                busy;

  line_cmd_scheduler #(
    .N_REQ (N_REQ),
    .CW    (CW),
    .H_RES (640),
    .V_RES (480)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_x0    (req_x0),
    .req_y0    (req_y0),
    .req_x1    (req_x1),
    .req_y1    (req_y1),
    .gnt       (gnt),
    .done      (done),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  pix_t  exp_q[$];
  line_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pix_cnt = 0;
  int done_count = 0;
  int last_hs_cyc = -100;
  int valid_rise_cyc = -1;
  int cur_first_x, cur_first_y, cur_last_x, cur_last_y;
  int done_first_x, done_first_y, done_last_x, done_last_y, done_cnt_seen;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [CW-1:0] prev_x = '0;
  logic [CW-1:0] prev_y = '0;
  logic          bp_en = 1'b0;
  pix_t          mon_p;
  line_t         mon_l;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference Bresenham walk; queues every pixel and returns the count
  function automatic int push_line(input int x0, input int y0, input int x1, input int y1);
    int x, y, dx, dy, sx, sy, err, e2, n;
    x = x0; y = y0; n = 0;
    dx  = (x1 > x0) ? (x1 - x0) : (x0 - x1);
    dy  = (y1 > y0) ? (y0 - y1) : (y1 - y0);
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    err = dx + dy;
    while (n < 5000) begin
      exp_q.push_back(pix_t'{x, y});
      n++;
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    return n;
  endfunction

  // Ready pattern: always high, or high about 30% of cycles
  always @(posedge clk) begin
    #1;
    pix_ready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      pix_cnt    = 0;
    end else begin
      if (gnt != '0) check("gnt_onehot", $countones(gnt), 1);
      if (prev_valid && !prev_ready) begin
        check("hold_valid", int'(pix_valid), 1);
        check("hold_xy", int'({pix_x, pix_y}), int'({prev_x, prev_y}));
      end
      if (pix_valid && !prev_valid) valid_rise_cyc = cyc;
      if (pix_valid && pix_ready) begin
        check("pix_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_p = exp_q.pop_front();
          check("pix_x", int'(pix_x), mon_p.x);
          check("pix_y", int'(pix_y), mon_p.y);
        end
        if (pix_cnt == 0) begin
          cur_first_x = int'(pix_x);
          cur_first_y = int'(pix_y);
        end
        cur_last_x  = int'(pix_x);
        cur_last_y  = int'(pix_y);
        pix_cnt++;
        last_hs_cyc = cyc;
      end
      if (done != '0) begin
        check("done_expected", int'(done_q.size() > 0), 1);
        if (done_q.size() > 0) begin
          mon_l = done_q.pop_front();
          check("done_owner", int'(done), 1 << mon_l.owner);
          check("line_pixels", pix_cnt, mon_l.cnt);
        end
        check("done_latency", cyc - last_hs_cyc, 1);
        done_first_x  = cur_first_x;
        done_first_y  = cur_first_y;
        done_last_x   = cur_last_x;
        done_last_y   = cur_last_y;
        done_cnt_seen = pix_cnt;
        pix_cnt = 0;
        done_count++;
      end
      prev_valid = pix_valid;
      prev_ready = pix_ready;
      prev_x     = pix_x;
      prev_y     = pix_y;
    end
  end

  task automatic set_cmd(input int r, input int x0, input int y0, input int x1, input int y1);
    req_x0[r*CW +: CW] = CW'(x0);
    req_y0[r*CW +: CW] = CW'(y0);
    req_x1[r*CW +: CW] = CW'(x1);
    req_y1[r*CW +: CW] = CW'(y1);
  endtask

  task automatic issue(input int r, input int x0, input int y0, input int x1, input int y1);
    @(posedge clk); #1;
    set_cmd(r, x0, y0, x1, y1);
    req[r] = 1'b1;
  endtask

  // Waits for a grant, reports the winner, releases its request
  task automatic wait_gnt(output int who, output int gcyc);
    bit got;
    got = 1'b0; who = -1; gcyc = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (gnt != '0) got = 1'b1;
    end
    check("gnt_seen", int'(got), 1);
    if (got) begin
      for (int b = N_REQ - 1; b >= 0; b--) if (gnt[b]) who = b;
      gcyc = cyc;
      @(posedge clk); #1;
      req[who] = 1'b0;
    end
  endtask

  task automatic wait_done(input int limit);
    int target;
    bit ok;
    target = done_count + 1;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(posedge clk);
      if (done_count >= target) ok = 1'b1;
    end
    check("done_seen", int'(ok), 1);
  endtask

  int who, gcyc, n, dc;
  int steep_x[9] = '{5, 5, 4, 4, 4, 4, 3, 3, 3};
  int steep_y[9] = '{10, 9, 8, 7, 6, 5, 4, 3, 2};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(pix_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pix_x", int'(pix_x), 0);
    check("rst_pix_y", int'(pix_y), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Shallow line from requester 0, ready always high
    n = push_line(1, 2, 40, 30);
    done_q.push_back(line_t'{0, n});
    issue(0, 1, 2, 40, 30);
    wait_gnt(who, gcyc);
    check("t1_gnt_who", who, 0);
    wait_done(200);
    check("t1_count", done_cnt_seen, 40);
    check("t1_first_x", done_first_x, 1);
    check("t1_first_y", done_first_y, 2);
    check("t1_last_x", done_last_x, 40);
    check("t1_last_y", done_last_y, 30);
    check("t1_gnt_to_valid", valid_rise_cyc - gcyc, 2);

    // Steep reverse line from requester 1, hand-walked table
    for (int i = 0; i < 9; i++) exp_q.push_back(pix_t'{steep_x[i], steep_y[i]});
    done_q.push_back(line_t'{1, 9});
    issue(1, 5, 10, 3, 2);
    wait_gnt(who, gcyc);
    check("t2_gnt_who", who, 1);
    wait_done(100);
    check("t2_count", done_cnt_seen, 9);
    check("t2_last_x", done_last_x, 3);
    check("t2_last_y", done_last_y, 2);

    // Degenerate single-pixel line
    exp_q.push_back(pix_t'{7, 7});
    done_q.push_back(line_t'{0, 1});
    issue(0, 7, 7, 7, 7);
    wait_gnt(who, gcyc);
    check("t3_gnt_who", who, 0);
    wait_done(50);
    check("t3_count", done_cnt_seen, 1);
    @(negedge clk);
    check("t3_busy_fall", int'(busy), 0);

    // Same shallow line under random backpressure
    n = push_line(1, 2, 40, 30);
    done_q.push_back(line_t'{1, n});
    bp_en = 1'b1;
    issue(1, 1, 2, 40, 30);
    wait_gnt(who, gcyc);
    check("t4_gnt_who", who, 1);
    wait_done(1500);
    bp_en = 1'b0;
    check("t4_count", done_cnt_seen, 40);
    check("t4_last_x", done_last_x, 40);

    // Both requesters held: alternate 0,1,0,1
    for (int k = 0; k < 2; k++) begin
      n = push_line(0, 0, 3, 1);
      done_q.push_back(line_t'{0, n});
      n = push_line(10, 5, 10, 8);
      done_q.push_back(line_t'{1, n});
    end
    @(posedge clk); #1;
    set_cmd(0, 0, 0, 3, 1);
    set_cmd(1, 10, 5, 10, 8);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(who, gcyc);
      check("rr_order", who, k % 2);
      wait_done(100);
      if (k < 2 && who >= 0) begin
        #1;
        req[who] = 1'b1;
      end
    end

    // Reset in the middle of a 40-pixel line
    n = push_line(1, 2, 40, 30);
    done_q.push_back(line_t'{0, n});
    issue(0, 1, 2, 40, 30);
    wait_gnt(who, gcyc);
    check("t6_gnt_who", who, 0);
    for (int i = 0; i < 200 && pix_cnt < 10; i++) @(posedge clk);
    check("t6_reach10", pix_cnt, 10);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", int'(pix_valid), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_gnt", int'(gnt), 0);
    check("t6_rst_done", int'(done), 0);
    check("t6_rst_pix_x", int'(pix_x), 0);
    check("t6_rst_pix_y", int'(pix_y), 0);
    exp_q.delete();
    done_q.delete();
    dc = done_count;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_done", done_count, dc);
    check("t6_idle_valid", int'(pix_valid), 0);

    // Fresh command after the abandoned one
    n = push_line(2, 3, 6, 3);
    done_q.push_back(line_t'{1, n});
    issue(1, 2, 3, 6, 3);
    wait_gnt(who, gcyc);
    check("t7_gnt_who", who, 1);
    wait_done(100);
    check("t7_count", done_cnt_seen, 5);
    check("t7_first_x", done_first_x, 2);
    check("t7_last_x", done_last_x, 6);
    check("t7_last_y", done_last_y, 3);
    check("t7_queue_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_cmd_scheduler.md
Name: line_cmd_scheduler

Overview:
- Accepts line-draw commands (two endpoints) from N requesters and arbitrates between them round-robin.
- Runs one all-octant Bresenham line at a time and streams the resulting pixel coordinates to the framebuffer writer over a valid/ready interface.
- Sits between the command sources (test-pattern generator, host port) and the framebuffer write port of the VGA pipeline.

Parameters:
- N_REQ, 2, number of requesters (1..8)
- CW, 10, coordinate width in bits (unsigned)
- H_RES, 640, visible width in pixels (used by the clip option)
- V_RES, 480, visible height in pixels (used by the clip option)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester command request; held high until the matching gnt pulse
- req_x0  in  N_REQ*CW  start X per requester; requester i uses slice i
- req_y0  in  N_REQ*CW  start Y per requester
- req_x1  in  N_REQ*CW  end X per requester
- req_y1  in  N_REQ*CW  end Y per requester
- gnt  out  N_REQ  one-cycle pulse; command from that requester accepted
- done  out  N_REQ  one-cycle pulse; that requester's line is fully emitted
- pix_valid  out  1  pix_x/pix_y hold a pixel to write
- pix_ready  in  1  framebuffer writer accepts the pixel
- pix_x  out  CW  pixel X
- pix_y  out  CW  pixel Y
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async) forces state IDLE; gnt, done, pix_valid and busy to 0; pix_x and pix_y to 0; round-robin pointer to 0.
- FSM states: IDLE -> SETUP -> DRAW -> DONE -> IDLE.
- IDLE:
  - If any req is high, pick the first set bit at or after the pointer, wrapping around.
  - At the next edge: latch that requester's four coordinates and its index (owner); pulse gnt[owner] for 1 cycle; go to SETUP.
- SETUP (1 cycle):
  - dx = |x1-x0|, dy = -|y1-y0|, sx = (x1>=x0)?+1:-1, sy = (y1>=y0)?+1:-1.
  - err = dx+dy; cur = (x0,y0).
  - Signed arithmetic, CW+2 bits wide.
  - Go to DRAW.
- DRAW:
  - pix_valid=1 and pix_x/pix_y = cur.
  - Outputs must stay stable while pix_ready=0.
  - On the cycle where pix_valid and pix_ready are both high:
    - if cur == (x1,y1), go to DONE;
    - otherwise step: e2 = 2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Both updates use the old err.
  - Pixel count = max(dx,|dy|)+1; the first pixel is (x0,y0) and the last is (x1,y1).
- DONE (1 cycle):
  - pulse done[owner]; pointer = owner+1 mod N_REQ; go to IDLE.
  - The earliest next gnt is in the cycle after DONE.
- Command latency: gnt to first pix_valid = 2 cycles.
- Degenerate line (x0==x1 and y0==y1): exactly one pixel, then DONE.
- req changes while busy are ignored; requests are only sampled in IDLE.
- Simultaneous requests: exactly one gnt; the losers keep req high and win in later rounds in rotation order.
- rst asserted mid-line: the line is abandoned immediately; no done pulse is issued and no further pixels are emitted.

Optional Feature:
- Macro LINE_SCHED_CLIP_EN.
- When defined:
  - A pixel with x>=H_RES or y>=V_RES is not presented; pix_valid stays low for it.
  - The stepper advances on its own at 1 pixel/cycle while off-screen.
  - The endpoint check still applies, and done fires normally.
  - If every pixel is off-screen, no pix_valid is ever seen and done still fires.
- When undefined: every computed pixel is presented, and H_RES/V_RES are unused.

Decomposition:
- Package line_pkg holds:
  - the state enum (IDLE, SETUP, DRAW, DONE);
  - CW and the err width (CW+2);
  - the default H_RES/V_RES.
- Sub-module bresenham_stepper:
  - inputs: load, endpoints, advance;
  - outputs: cur_x, cur_y, at_end;
  - owns dx/dy/sx/sy/err.
- The top level owns the arbiter, the FSM and the handshake.

Test Plan:
- Requester 0 sends (1,2)->(40,30), pix_ready tied 1:
  - exactly 40 pixels; first (1,2), last (40,30);
  - done[0] 1 cycle after the last handshake;
  - gnt[0] to first pix_valid = 2 cycles.
- Steep reverse line (5,10)->(3,2): 9 pixels, y strictly decreasing by 1 per pixel, last (3,2).
- Degenerate (7,7)->(7,7): exactly one pixel (7,7), then done pulse, busy falls.
- Backpressure with pix_ready random at ~30%: pix_x/pix_y never change while pix_valid=1 and pix_ready=0; the pixel sequence is identical to the ready=1 run.
- req=2'b11 held with pointer 0: gnt order 0,1,0,1 over four commands, never two gnt bits at once.
- rst pulsed after the 10th pixel of a 40-pixel line: all outputs 0 asynchronously, no done; the next command draws correctly from its own start.
